// File: rtl/issue_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// issue_hazard_ctrl
//
// This block is the sequencing controller for the in-order issue stage. It
// keeps a load scoreboard and a count of in-flight LSU ops. From these it
// drives the issue-stage stall and flush. A RUN/FLUSH/DRAIN FSM handles
// taken branches/jumps and fences.
//
// Parameters
//   MAX_OUTSTANDING : max in-flight LSU ops (1..15)
//   FLUSH_CYCLES    : cycles o_flush is held after a taken branch/jump (1..7)
//   CNT_W           : outstanding-counter width (derived, do not override)
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_iss_*               : uop currently held in the issue register
//   i_branch_taken        : issue stage resolved a taken branch/jump
//   i_lsu_stall           : LSU back-pressure
//   i_lsu_wb_valid/_wb_rd : load write-back this cycle and its destination
//   i_lsu_done            : one LSU op (load or store) completed
//   o_stall, o_flush      : stall / flush to the issue and decode registers
//   o_busy_mask           : scoreboard, bit n = load pending to xn
//   o_outstanding         : in-flight LSU op count
//   o_state               : FSM state (RUN=0, FLUSH=1, DRAIN=2)
//   o_err                 : sticky counter-underflow error
//
// Optional build macro
//   HAZARD_PERF_CNT_EN : adds the saturating 32-bit counters o_raw_stall_cnt,
//                        o_full_stall_cnt and o_flush_cnt.
//
// Issue handshake: i_iss_valid acts as "valid" and (!o_stall & !o_flush) acts
// as "ready". A uop fires (is consumed) in a RUN cycle where both are true.
// A fence that still has to drain is the exception: it is held until the
// drain completes, and then it fires.
// -----------------------------------------------------------------------------
module issue_hazard_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FLUSH_CYCLES    = 1,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_iss_valid,
  input  logic [4:0]       i_iss_rs1,
  input  logic [4:0]       i_iss_rs2,
  input  logic             i_iss_uses_rs1,
  input  logic             i_iss_uses_rs2,
  input  logic [4:0]       i_iss_rd,
  input  logic             i_iss_is_load,
  input  logic             i_iss_is_store,
  input  logic             i_iss_is_fence,
  input  logic             i_branch_taken,
  input  logic             i_lsu_stall,
  input  logic             i_lsu_wb_valid,
  input  logic [4:0]       i_lsu_wb_rd,
  input  logic             i_lsu_done,
  output logic             o_stall,
  output logic             o_flush,
  output logic [31:0]      o_busy_mask,
  output logic [CNT_W-1:0] o_outstanding,
  output logic [1:0]       o_state,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      o_raw_stall_cnt,
  output logic [31:0]      o_full_stall_cnt,
  output logic [31:0]      o_flush_cnt,
`endif
  output logic             o_err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_OUTSTANDING);
  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [31:0]      sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  // This bit is set when DRAIN completes. It lets the held fence fire
  // instead of entering DRAIN again.
  logic             fence_go_q, fence_go_d;

  logic [31:0] clr_mask, set_mask, eff_sb;
  logic        is_lsu, raw_haz, full_haz, flush, stall, fence_hold, fire;
  logic        inc, dec;

  // Hazard detection and issue control
  always_comb begin
    clr_mask = '0;
    if (i_lsu_wb_valid) clr_mask[i_lsu_wb_rd] = 1'b1;
    // A same-cycle write-back is forwarded at retire, so it is not a hazard.
    eff_sb   = sb_q & ~clr_mask;
    is_lsu   = i_iss_is_load | i_iss_is_store;
    raw_haz  = i_iss_valid & ((i_iss_uses_rs1 & eff_sb[i_iss_rs1]) |
                              (i_iss_uses_rs2 & eff_sb[i_iss_rs2]));
    // A completion in the same cycle frees the slot that a new op would take.
    full_haz = i_iss_valid & is_lsu & (cnt_q == MAX_C) & ~i_lsu_done;
    flush    = (state_q == ST_FLUSH);
    stall    = ~flush & ((state_q == ST_DRAIN) |
                         ((state_q == ST_RUN) & (raw_haz | full_haz | i_lsu_stall)));
    fence_hold = (state_q == ST_RUN) & i_iss_valid & i_iss_is_fence & ~fence_go_q;
    fire     = (state_q == ST_RUN) & i_iss_valid & ~stall & ~flush & ~fence_hold;
  end

  // Scoreboard and outstanding counter
  always_comb begin
    set_mask = '0;
    if (fire && i_iss_is_load && (i_iss_rd != 5'd0)) set_mask[i_iss_rd] = 1'b1;
    // If set and clear hit the same rd, set wins.
    sb_d    = (sb_q & ~clr_mask) | set_mask;
    sb_d[0] = 1'b0;

    inc   = fire & is_lsu;
    dec   = i_lsu_done;
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc && dec) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // FSM next state
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    fence_go_d = fence_go_q;
    case (state_q)
      ST_RUN: begin
        if (fire || !i_iss_valid) fence_go_d = 1'b0;
        if (fence_hold && !raw_haz) begin
          state_d = ST_DRAIN;
        end else if (i_branch_taken && i_iss_valid && !stall) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        // Branches seen here are ignored. Flush lasts FLUSH_CYCLES cycles.
        fcnt_d = fcnt_q - 3'd1;
        if (fcnt_q <= 3'd1) begin
          state_d = ST_RUN;
          fcnt_d  = 3'd0;
        end
      end
      ST_DRAIN: begin
        if ((cnt_q == '0) && (sb_q == '0)) begin
          state_d    = ST_RUN;
          fence_go_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fcnt_q     <= 3'd0;
      sb_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      fence_go_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      sb_q       <= sb_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fence_go_q <= fence_go_d;
    end
  end

  assign o_stall       = stall;
  assign o_flush       = flush;
  assign o_busy_mask   = sb_q;
  assign o_outstanding = cnt_q;
  assign o_state       = state_q;
  assign o_err         = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic raw_evt, full_evt;
  assign raw_evt  = (state_q == ST_RUN) & ~flush & raw_haz;
  assign full_evt = (state_q == ST_RUN) & ~flush & full_haz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_raw_stall_cnt  <= '0;
      o_full_stall_cnt <= '0;
      o_flush_cnt      <= '0;
    end else begin
      if (raw_evt  && (o_raw_stall_cnt  != '1)) o_raw_stall_cnt  <= o_raw_stall_cnt  + 32'd1;
      if (full_evt && (o_full_stall_cnt != '1)) o_full_stall_cnt <= o_full_stall_cnt + 32'd1;
      if (flush    && (o_flush_cnt      != '1)) o_flush_cnt      <= o_flush_cnt      + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_hazard_ctrl
//
// This bench runs directed scenarios for issue_hazard_ctrl and then a
// randomized run. It compares the DUT against a behavioural model: a queue of
// in-flight LSU ops, a busy-register vector and a small phase tracker.
// -----------------------------------------------------------------------------
module tb_issue_hazard_ctrl;

  localparam int MAX_OUT = 4;
  localparam int FC      = 2;
  localparam int CW      = $clog2(MAX_OUT + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          i_iss_valid, i_iss_uses_rs1, i_iss_uses_rs2;
  logic [4:0]    i_iss_rs1, i_iss_rs2, i_iss_rd, i_lsu_wb_rd;
  logic          i_iss_is_load, i_iss_is_store, i_iss_is_fence;
  logic          i_branch_taken, i_lsu_stall, i_lsu_wb_valid, i_lsu_done;
  logic          o_stall, o_flush, o_err;
  logic [31:0]   o_busy_mask;
  logic [CW-1:0] o_outstanding;
  logic [1:0]    o_state;

  issue_hazard_ctrl #(.MAX_OUTSTANDING(MAX_OUT), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_iss_valid(i_iss_valid), .i_iss_rs1(i_iss_rs1), .i_iss_rs2(i_iss_rs2),
    .i_iss_uses_rs1(i_iss_uses_rs1), .i_iss_uses_rs2(i_iss_uses_rs2),
    .i_iss_rd(i_iss_rd), .i_iss_is_load(i_iss_is_load),
    .i_iss_is_store(i_iss_is_store), .i_iss_is_fence(i_iss_is_fence),
    .i_branch_taken(i_branch_taken), .i_lsu_stall(i_lsu_stall),
    .i_lsu_wb_valid(i_lsu_wb_valid), .i_lsu_wb_rd(i_lsu_wb_rd),
    .i_lsu_done(i_lsu_done),
    .o_stall(o_stall), .o_flush(o_flush), .o_busy_mask(o_busy_mask),
    .o_outstanding(o_outstanding), .o_state(o_state), .o_err(o_err)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Phase: 0 running, 1 flushing, 2 draining for a fence.
  int          m_state;
  int          m_flush_left;
  logic [31:0] m_busy;
  logic [4:0]  exp_q[$];     // one entry per in-flight LSU op
  bit          m_err, m_fence_go;
  bit          m_raw, m_fire, m_fence_hold, exp_stall, exp_flush;

  task automatic model_reset();
    m_state = 0; m_flush_left = 0; m_busy = '0; exp_q.delete();
    m_err = 0; m_fence_go = 0;
  endtask

  task automatic model_eval();
    logic [31:0] eff;
    bit full;
    eff = m_busy;
    if (i_lsu_wb_valid) eff[i_lsu_wb_rd] = 1'b0;
    m_raw = i_iss_valid && ((i_iss_uses_rs1 && eff[i_iss_rs1]) ||
                            (i_iss_uses_rs2 && eff[i_iss_rs2]));
    full  = i_iss_valid && (i_iss_is_load || i_iss_is_store) &&
            (exp_q.size() == MAX_OUT) && !i_lsu_done;
    exp_flush = (m_state == 1);
    exp_stall = !exp_flush && (m_state == 2 ||
                (m_state == 0 && (m_raw || full || i_lsu_stall)));
    m_fence_hold = (m_state == 0) && i_iss_valid && i_iss_is_fence && !m_fence_go;
    m_fire = (m_state == 0) && i_iss_valid && !exp_stall && !exp_flush && !m_fence_hold;
  endtask

  task automatic model_update();
    case (m_state)
      0: begin
        if (m_fire || !i_iss_valid) m_fence_go = 0;
        if (m_fence_hold && !m_raw) m_state = 2;
        else if (i_branch_taken && i_iss_valid && !exp_stall) begin
          m_state = 1; m_flush_left = FC;
        end
      end
      1: begin
        m_flush_left--;
        if (m_flush_left == 0) m_state = 0;
      end
      default: if (exp_q.size() == 0 && m_busy == 0) begin
        m_state = 0; m_fence_go = 1;
      end
    endcase
    if (i_lsu_wb_valid) m_busy[i_lsu_wb_rd] = 1'b0;
    if (m_fire && i_iss_is_load && i_iss_rd != 0) m_busy[i_iss_rd] = 1'b1;
    if (m_fire && (i_iss_is_load || i_iss_is_store)) exp_q.push_back(i_iss_rd);
    if (i_lsu_done) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else m_err = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    i_iss_valid = 0; i_iss_rs1 = 0; i_iss_rs2 = 0; i_iss_uses_rs1 = 0;
    i_iss_uses_rs2 = 0; i_iss_rd = 0; i_iss_is_load = 0; i_iss_is_store = 0;
    i_iss_is_fence = 0; i_branch_taken = 0; i_lsu_stall = 0;
    i_lsu_wb_valid = 0; i_lsu_wb_rd = 0; i_lsu_done = 0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    drive_idle();
    i_iss_valid = 1; i_iss_is_load = 1; i_iss_rd = rd;
  endtask

  // Moves one clock edge and updates the model from the inputs held across
  // that edge. It returns at the following negedge.
  task automatic advance();
    model_eval();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    model_reset();
    #1;
    checks++; if ({o_stall, o_flush, o_err} !== 3'b000) begin failures++;
      $display("FAIL reset_flags: got stall/flush/err=%b want 000", {o_stall, o_flush, o_err}); end
    checks++; if (o_busy_mask !== 32'h0 || o_outstanding !== '0 || o_state !== 2'd0) begin failures++;
      $display("FAIL reset_state: got busy=%h cnt=%0d st=%0d want 0/0/0", o_busy_mask, o_outstanding, o_state); end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_raw();
    do_reset();
    drive_load(5'd5);
    #1; checks++; if (o_stall !== 1'b0) begin failures++;
      $display("FAIL raw_load_issue: got stall=%b want 0", o_stall); end
    advance();
    drive_idle();
    i_iss_valid = 1; i_iss_uses_rs1 = 1; i_iss_rs1 = 5; i_iss_rd = 6;
    #1; checks++; if (o_stall !== 1'b1) begin failures++;
      $display("FAIL raw_stall: got %b want 1", o_stall); end
    checks++; if (o_busy_mask !== 32'h20) begin failures++;
      $display("FAIL raw_busy: got %h want 00000020", o_busy_mask); end
    i_lsu_wb_valid = 1; i_lsu_wb_rd = 5;
    #1; checks++; if (o_stall !== 1'b0) begin failures++;
      $display("FAIL raw_wb_forward: got stall=%b want 0", o_stall); end
    advance();
    drive_idle();
    #1; checks++; if (o_busy_mask !== 32'h0 || o_outstanding !== CW'(1)) begin failures++;
      $display("FAIL raw_wb_clear: got busy=%h cnt=%0d want 0/1", o_busy_mask, o_outstanding); end
  endtask

  task automatic test_full();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      drive_load(5'(r));
      advance();
    end
    drive_load(5'd6);
    #1; checks++; if (o_outstanding !== CW'(4) || o_stall !== 1'b1) begin failures++;
      $display("FAIL full_stall: got cnt=%0d stall=%b want 4/1", o_outstanding, o_stall); end
    advance();
    #1; checks++; if (o_stall !== 1'b1) begin failures++;
      $display("FAIL full_hold: got stall=%b want 1", o_stall); end
    i_lsu_done = 1;
    #1; checks++; if (o_stall !== 1'b0) begin failures++;
      $display("FAIL full_done_release: got stall=%b want 0", o_stall); end
    advance();
    drive_idle();
    #1; checks++; if (o_outstanding !== CW'(4) || o_busy_mask !== 32'h5E) begin failures++;
      $display("FAIL full_after: got cnt=%0d busy=%h want 4/0000005e", o_outstanding, o_busy_mask); end
  endtask

  task automatic test_flush();
    int nflush;
    do_reset();
    drive_idle();
    i_iss_valid = 1; i_branch_taken = 1;
    #1; checks++; if (o_flush !== 1'b0 || o_stall !== 1'b0) begin failures++;
      $display("FAIL flush_entry: got flush=%b stall=%b want 0/0", o_flush, o_stall); end
    advance();
    nflush = 0;
    for (int c = 0; c < 5; c++) begin
      // The branch stays asserted through the flush window.
      if (c >= FC) drive_idle();
      #1;
      if (c < FC) begin
        checks++; if (o_flush !== 1'b1 || o_state !== 2'd1) begin failures++;
          $display("FAIL flush_window: cyc=%0d got flush=%b st=%0d want 1/1", c, o_flush, o_state); end
      end
      if (o_flush === 1'b1) nflush++;
      advance();
    end
    checks++; if (nflush != FC) begin failures++;
      $display("FAIL flush_len: got %0d cycles want %0d", nflush, FC); end
    #1; checks++; if (o_state !== 2'd0) begin failures++;
      $display("FAIL flush_exit: got st=%0d want 0", o_state); end
  endtask

  task automatic test_fence();
    do_reset();
    drive_load(5'd3); advance();
    drive_idle(); i_iss_valid = 1; i_iss_is_store = 1; advance();
    drive_idle(); i_iss_valid = 1; i_iss_is_fence = 1;
    #1; checks++; if (o_state !== 2'd0 || o_outstanding !== CW'(2) || o_busy_mask !== 32'h8) begin failures++;
      $display("FAIL fence_pre: got st=%0d cnt=%0d busy=%h want 0/2/8", o_state, o_outstanding, o_busy_mask); end
    advance();
    #1; checks++; if (o_state !== 2'd2 || o_stall !== 1'b1) begin failures++;
      $display("FAIL fence_drain: got st=%0d stall=%b want 2/1", o_state, o_stall); end
    i_lsu_done = 1; advance();
    i_lsu_wb_valid = 1; i_lsu_wb_rd = 3; advance();
    i_lsu_done = 0; i_lsu_wb_valid = 0;
    #1; checks++; if (o_state !== 2'd2 || o_stall !== 1'b1 || o_outstanding !== '0 || o_busy_mask !== 32'h0) begin failures++;
      $display("FAIL fence_empty: got st=%0d stall=%b cnt=%0d busy=%h want 2/1/0/0", o_state, o_stall, o_outstanding, o_busy_mask); end
    advance();
    #1; checks++; if (o_state !== 2'd0 || o_stall !== 1'b0) begin failures++;
      $display("FAIL fence_resume: got st=%0d stall=%b want 0/0", o_state, o_stall); end
    advance();
    drive_idle();
    #1; checks++; if (o_state !== 2'd0) begin failures++;
      $display("FAIL fence_fired: got st=%0d want 0", o_state); end
  endtask

  task automatic test_err_reset();
    do_reset();
    i_lsu_done = 1; advance();
    drive_idle();
    #1; checks++; if (o_err !== 1'b1 || o_outstanding !== '0) begin failures++;
      $display("FAIL err_set: got err=%b cnt=%0d want 1/0", o_err, o_outstanding); end
    advance();
    #1; checks++; if (o_err !== 1'b1) begin failures++;
      $display("FAIL err_sticky: got %b want 1", o_err); end
    drive_load(5'd9); advance();
    drive_idle(); i_iss_valid = 1; i_iss_is_fence = 1; advance();
    #1; checks++; if (o_state !== 2'd2) begin failures++;
      $display("FAIL err_drain_entry: got st=%0d want 2", o_state); end
    #1; rst_n = 0;
    #1; checks++; if ({o_stall, o_flush, o_err} !== 3'b000 || o_busy_mask !== 32'h0 ||
                      o_outstanding !== '0 || o_state !== 2'd0) begin failures++;
      $display("FAIL async_reset: got stall=%b flush=%b err=%b busy=%h cnt=%0d st=%0d want all 0",
               o_stall, o_flush, o_err, o_busy_mask, o_outstanding, o_state); end
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_rd0();
    do_reset();
    drive_load(5'd0); advance();
    drive_load(5'd7); i_lsu_wb_valid = 1; i_lsu_wb_rd = 7;
    #1; checks++; if (o_busy_mask !== 32'h0) begin failures++;
      $display("FAIL rd0_busy: got %h want 0", o_busy_mask); end
    advance();
    drive_idle();
    #1; checks++; if (o_busy_mask !== 32'h80 || o_outstanding !== CW'(2)) begin failures++;
      $display("FAIL set_wins: got busy=%h cnt=%0d want 00000080/2", o_busy_mask, o_outstanding); end
  endtask

  task automatic test_random();
    int cand;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_idle();
      i_iss_valid    = ($urandom_range(0, 9) < 8);
      i_iss_rs1      = 5'($urandom_range(0, 15));
      i_iss_rs2      = 5'($urandom_range(0, 15));
      i_iss_uses_rs1 = $urandom_range(0, 1);
      i_iss_uses_rs2 = $urandom_range(0, 1);
      i_iss_rd       = 5'($urandom_range(0, 15));
      case ($urandom_range(0, 99)) inside
        [0:29]:  i_iss_is_load  = 1;
        [30:44]: i_iss_is_store = 1;
        [45:47]: i_iss_is_fence = 1;
        [48:52]: i_branch_taken = 1;
        default: ;
      endcase
      i_lsu_stall    = ($urandom_range(0, 9) == 0);
      i_lsu_wb_valid = ($urandom_range(0, 3) == 0);
      i_lsu_wb_rd    = 5'($urandom_range(0, 15));
      if (m_busy != 0 && $urandom_range(0, 1) == 1) begin
        cand = 0;
        for (int k = 0; k < 32; k++) if (m_busy[k]) cand = k;
        i_lsu_wb_rd = 5'(cand);
      end
      i_lsu_done = (exp_q.size() > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      #1;
      model_eval();
      checks++; if (o_stall !== exp_stall || o_flush !== exp_flush) begin failures++;
        $display("FAIL rnd_ctrl: cyc=%0d got stall=%b flush=%b want %b/%b", i, o_stall, o_flush, exp_stall, exp_flush); end
      checks++; if (o_busy_mask !== m_busy || o_outstanding !== CW'(exp_q.size())) begin failures++;
        $display("FAIL rnd_track: cyc=%0d got busy=%h cnt=%0d want %h/%0d", i, o_busy_mask, o_outstanding, m_busy, exp_q.size()); end
      checks++; if (o_state !== 2'(m_state) || o_err !== m_err) begin failures++;
        $display("FAIL rnd_state: cyc=%0d got st=%0d err=%b want %0d/%b", i, o_state, o_err, m_state, m_err); end
      @(posedge clk);
      model_update();
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_raw();
    test_full();
    test_flush();
    test_fence();
    test_err_reset();
    test_rd0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
Sequencing controller for the in-order issue stage. Holds a load scoreboard and an outstanding-LSU counter, and generates the issue-stage stall and flush. Runs a RUN/FLUSH/DRAIN FSM for taken branches and fences. Sits beside the issue stage: it observes the uop held in the issue register, LSU dispatch/completion and write-back, and drives the issue stall/flush inputs.

Parameters:
MAX_OUTSTANDING, 4, max in-flight LSU ops (1..15)
FLUSH_CYCLES, 1, cycles o_flush is held after a taken branch/jump (1..7)
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding-counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_iss_valid  in  1  issue register holds a valid uop
i_iss_rs1  in  5  source reg 1
i_iss_rs2  in  5  source reg 2
i_iss_uses_rs1  in  1  uop reads rs1
i_iss_uses_rs2  in  1  uop reads rs2
i_iss_rd  in  5  destination reg
i_iss_is_load  in  1  uop is a LOAD
i_iss_is_store  in  1  uop is a STORE
i_iss_is_fence  in  1  uop is a FENCE
i_branch_taken  in  1  issue stage resolved a taken branch/jump this cycle
i_lsu_stall  in  1  LSU back-pressure
i_lsu_wb_valid  in  1  load data written back this cycle
i_lsu_wb_rd  in  5  write-back destination
i_lsu_done  in  1  one LSU op (load or store) completed
o_stall  out  1  stall to issue stage
o_flush  out  1  flush to decode/issue registers
o_busy_mask  out  32  scoreboard (bit n = load pending to xn)
o_outstanding  out  CNT_W  in-flight LSU op count
o_state  out  2  FSM state: RUN=0, FLUSH=1, DRAIN=2
o_err  out  1  sticky underflow error

Behaviour:
- Reset (async): sb=0, cnt=0, state=RUN, flush counter=0, o_err=0. o_stall=0, o_flush=0.
- clr_mask = i_lsu_wb_valid ? (1<<i_lsu_wb_rd) : 0. eff_sb = sb & ~clr_mask (same-cycle write-back is forwarded by retire, so no hazard).
- raw_haz = i_iss_valid & ((uses_rs1 & eff_sb[rs1]) | (uses_rs2 & eff_sb[rs2])). Reg 0 is never busy.
- full_haz = i_iss_valid & (is_load|is_store) & (cnt==MAX_OUTSTANDING) & !i_lsu_done.
- o_stall (comb) = state==DRAIN | (state==RUN & (raw_haz | full_haz | i_lsu_stall)). Forced 0 while o_flush=1.
- fire = state==RUN & i_iss_valid & !o_stall & !o_flush.
- Scoreboard update: sb_next = (sb & ~clr_mask) | set_mask. set_mask = fire & is_load & rd!=0 ? 1<<rd : 0. Set wins over clear on the same rd. bit0 forced 0.
- Counter: inc = fire & (is_load|is_store); dec = i_lsu_done. inc&dec leaves cnt unchanged. dec at cnt==0 with no inc: cnt stays 0 and o_err sets; o_err clears only on reset.
- FSM:
  - RUN -> FLUSH when i_branch_taken & i_iss_valid & !o_stall. The branch itself fires that cycle. Load flush counter = FLUSH_CYCLES.
  - RUN -> DRAIN when i_iss_valid & is_fence & !raw_haz (the fence does not fire).
  - FLUSH: o_flush=1 (registered, asserted the cycle after entry) for exactly FLUSH_CYCLES cycles, then -> RUN. Branches seen in FLUSH are ignored.
  - DRAIN: o_stall=1 until cnt==0 & sb==0, then -> RUN next cycle. The fence then fires.
- LSU completions and write-backs are accepted in every state.
- Reset mid-FLUSH/DRAIN returns immediately to RUN with all state cleared.

Optional Feature:
HAZARD_PERF_CNT_EN: when defined, adds outputs o_raw_stall_cnt[31:0], o_full_stall_cnt[31:0] and o_flush_cnt[31:0]. These count cycles with raw_haz stall, full_haz stall, and o_flush asserted. They saturate at 0xFFFFFFFF and reset to 0. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Load x5 fires; next cycle ADD uses rs1=x5 -> o_stall=1, busy_mask=0x20. Assert i_lsu_wb_valid rd=5 -> o_stall=0 the same cycle, busy_mask=0 next cycle.
- Issue 4 loads (rd=1..4) with no done -> o_outstanding=4. A 5th load stalls. i_lsu_done with the 5th load present -> fires, count stays 4.
- Taken JAL in RUN, FLUSH_CYCLES=2 -> o_flush=1 for exactly 2 cycles starting the next cycle, o_state=1, then RUN. A second branch during FLUSH produces no extra flush.
- FENCE with cnt=2, sb=0x8 -> DRAIN, o_stall=1. Two dones plus wb rd=3 -> RUN one cycle after cnt=0 & sb=0.
- i_lsu_done at cnt=0 -> o_err=1 sticky, o_outstanding stays 0. Async rst_n low during DRAIN -> all outputs 0, state RUN.
- Load rd=0 fires -> busy_mask remains 0. Load rd=7 fires with simultaneous wb rd=7 -> bit7 set.
